// File: rtl/dmem_write_buffer_if.sv
// -----------------------------------------------------------------------------
// dmem_write_buffer_if
// Bundles the cpu data-port signals and the dmem port signals seen by the
// posted-store write buffer.
//   slave  : the write buffer's view (cpu requests and dmem read data in;
//            load data, stall, dmem strobes/address/data and empty out)
//   master : the surrounding cpu/dmem view (directions reversed)
// Signals:
//   MemWr, MemRd, address, DataIn : cpu store/load request
//   Dataout, stall                : cpu load data, store refusal
//   mem_wr, mem_rd, mem_addr,
//   mem_din, mem_dout             : single-ported dmem access
//   empty                         : no stores buffered
// -----------------------------------------------------------------------------
interface dmem_write_buffer_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              MemWr;
    logic              MemRd;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] DataIn;
    logic [DATA_W-1:0] Dataout;
    logic              stall;
    logic              mem_wr;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;
    logic              empty;

    modport master (
        output MemWr, MemRd, address, DataIn, mem_dout,
        input  Dataout, stall, mem_wr, mem_rd, mem_addr, mem_din, empty
    );

    modport slave (
        input  MemWr, MemRd, address, DataIn, mem_dout,
        output Dataout, stall, mem_wr, mem_rd, mem_addr, mem_din, empty
    );
endinterface

// File: rtl/dmem_write_buffer.sv
// -----------------------------------------------------------------------------
// dmem_write_buffer
// Posted-store FIFO between the cpu data port and dmem. cpu stores are queued
// without stalling (unless the queue is full), retired to dmem one per cycle
// in issue order, and buffered data is forwarded to cpu loads that hit a
// queued address. A load that misses the queue takes the dmem port for that
// cycle and blocks draining.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-low reset; discards all queued stores
//   bus   : dmem_write_buffer_if.slave (cpu request side and dmem side)
// -----------------------------------------------------------------------------
module dmem_write_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    dmem_write_buffer_if.slave    bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];

    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;

    logic              full;
    logic              push;
    logic              drain;
    logic              hit;
    logic              load_miss;
    logic [DATA_W-1:0] hit_data;
    logic [PTR_W-1:0]  idx;

    // Walk valid entries oldest to youngest; a later match overrides an
    // earlier one, so the youngest matching store wins the forward.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if ((CNT_W'(i) < count) && (addr_mem[idx] == bus.address)) begin
                hit      = 1'b1;
                hit_data = data_mem[idx];
            end
        end
    end

    assign full      = (count == CNT_W'(DEPTH));
    assign load_miss = bus.MemRd & ~hit;
    // A load miss owns the single dmem port, so draining waits a cycle.
    assign drain     = (count != '0) & ~load_miss;
    // No fall-through: a full queue refuses even when it drains this cycle.
    assign push      = bus.MemWr & ~full;

    // Outputs are forced quiet while reset is held.
    always_comb begin
        bus.stall    = reset & bus.MemWr & full;
        bus.mem_rd   = reset & load_miss;
        bus.mem_wr   = reset & drain;
        bus.mem_addr = '0;
        bus.mem_din  = '0;
        bus.Dataout  = '0;
        bus.empty    = (count == '0);
        if (reset) begin
            if (load_miss) begin
                bus.mem_addr = bus.address;
            end else if (drain) begin
                bus.mem_addr = addr_mem[head];
                bus.mem_din  = data_mem[head];
            end
            if (bus.MemRd) begin
                bus.Dataout = hit ? hit_data : bus.mem_dout;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push)  tail <= tail + PTR_W'(1);
            if (drain) head <= head + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(drain);
        end
    end

    // Entry storage carries no reset; validity is defined by head/count.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[tail] <= bus.address;
            data_mem[tail] <= bus.DataIn;
        end
    end
endmodule

// File: tb/tb_dmem_write_buffer.sv
// -----------------------------------------------------------------------------
// tb_dmem_write_buffer
// Self-checking bench for dmem_write_buffer. A queue of {address,data} stands
// for the buffered stores; every cycle the expected dmem/cpu outputs are
// derived from that queue and compared with the DUT, then the queue is
// updated (pop on drain, push on accepted store).
// -----------------------------------------------------------------------------
module tb_dmem_write_buffer;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n;

    dmem_write_buffer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    dmem_write_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    ent_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   wr_pulses = 0;

    logic [DATA_W-1:0] obs_dout;
    logic [DATA_W-1:0] obs_mem_dout;
    logic [ADDR_W-1:0] obs_mem_addr;
    logic              obs_stall;
    logic              obs_mem_rd;
    logic              obs_empty;
    logic              obs_mem_wr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at the falling edge, check 1 time unit later,
    // update the reference queue at the rising edge, return at next falling edge.
    task automatic step(input logic wr, input logic rd,
                        input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        logic              e_stall, e_wr, e_rd, e_empty, hit, do_drain;
        logic [ADDR_W-1:0] e_addr;
        logic [DATA_W-1:0] e_din, e_dout, hd;
        bus.MemWr    = wr;
        bus.MemRd    = rd;
        bus.address  = a;
        bus.DataIn   = d;
        bus.mem_dout = DATA_W'($urandom);
        #1;
        hit = 1'b0;
        hd  = '0;
        foreach (q[i]) if (q[i].a == a) begin hit = 1'b1; hd = q[i].d; end
        e_stall = 1'b0; e_wr = 1'b0; e_rd = 1'b0; e_addr = '0; e_din = '0;
        e_dout  = '0;   do_drain = 1'b0;
        e_empty = (q.size() == 0);
        if (rst_n) begin
            e_stall = wr && (q.size() == DEPTH);
            if (rd && !hit) begin
                e_rd   = 1'b1;
                e_addr = a;
            end else if (q.size() != 0) begin
                e_wr     = 1'b1;
                e_addr   = q[0].a;
                e_din    = q[0].d;
                do_drain = 1'b1;
            end
            if (rd) e_dout = hit ? hd : bus.mem_dout;
        end
        chk("empty",    32'(bus.empty),    32'(e_empty));
        chk("stall",    32'(bus.stall),    32'(e_stall));
        chk("mem_wr",   32'(bus.mem_wr),   32'(e_wr));
        chk("mem_rd",   32'(bus.mem_rd),   32'(e_rd));
        chk("mem_addr", 32'(bus.mem_addr), 32'(e_addr));
        chk("mem_din",  32'(bus.mem_din),  32'(e_din));
        chk("Dataout",  32'(bus.Dataout),  32'(e_dout));
        obs_dout     = bus.Dataout;
        obs_mem_dout = bus.mem_dout;
        obs_mem_addr = bus.mem_addr;
        obs_stall    = bus.stall;
        obs_mem_rd   = bus.mem_rd;
        obs_empty    = bus.empty;
        obs_mem_wr   = bus.mem_wr;
        if (bus.mem_wr === 1'b1) wr_pulses++;
        @(posedge clk);
        if (rst_n) begin
            if (do_drain) void'(q.pop_front());
            if (wr && !e_stall) q.push_back('{a: a, d: d});
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.MemWr    = 1'b0;
        bus.MemRd    = 1'b0;
        bus.address  = '0;
        bus.DataIn   = '0;
        bus.mem_dout = '0;
        @(negedge clk);
        // Reset state, including a load request held during reset.
        step(1'b0, 1'b1, 16'h0040, '0);
        chk("rst_empty", 32'(obs_empty), 32'd1);
        chk("rst_dout",  32'(obs_dout),  32'd0);
        step(1'b1, 1'b0, 16'h0044, 16'h5555);
        rst_n = 1'b1;
        idle(1);

        // Back-to-back stores retire in order, buffer empties again.
        step(1'b1, 1'b0, 16'h0010, 16'hAAAA);
        step(1'b1, 1'b0, 16'h0012, 16'hBBBB);
        chk("t2_first_addr", 32'(obs_mem_addr), 32'h0010);
        idle(1);
        chk("t2_second_addr", 32'(obs_mem_addr), 32'h0012);
        idle(1);
        chk("t2_empty", 32'(obs_empty), 32'd1);

        // Forwarding: immediate load of a just-stored address.
        step(1'b1, 1'b0, 16'h0020, 16'h1234);
        step(1'b0, 1'b1, 16'h0020, '0);
        chk("t3_fwd",    32'(obs_dout),   32'h1234);
        chk("t3_no_rd",  32'(obs_mem_rd), 32'd0);
        idle(2);
        step(1'b1, 1'b1, 16'h0020, 16'h0001);
        step(1'b1, 1'b1, 16'h0020, 16'h0002);
        step(1'b0, 1'b1, 16'h0020, '0);
        chk("t3_youngest", 32'(obs_dout), 32'h0002);
        idle(4);

        // Fill with load misses blocking drain; 5th store stalls.
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b1, 16'(16'h0030 + 2 * k), 16'(16'hC000 + k));
            chk("t4_stall", 32'(obs_stall), (k == 4) ? 32'd1 : 32'd0);
        end
        step(1'b1, 1'b0, 16'h0038, 16'hC004);
        chk("t4_stall_on_drain", 32'(obs_stall), 32'd1);
        chk("t4_drain0", 32'(obs_mem_addr), 32'h0030);
        step(1'b1, 1'b0, 16'h0038, 16'hC004);
        chk("t4_accept", 32'(obs_stall), 32'd0);
        idle(6);

        // Load miss with two entries queued takes the dmem port.
        step(1'b1, 1'b1, 16'h0050, 16'h0D50);
        step(1'b1, 1'b1, 16'h0052, 16'h0D52);
        step(1'b0, 1'b1, 16'h0040, '0);
        chk("t5_rd",   32'(obs_mem_rd),   32'd1);
        chk("t5_addr", 32'(obs_mem_addr), 32'h0040);
        chk("t5_dout", 32'(obs_dout),     32'(obs_mem_dout));
        chk("t5_no_wr", 32'(obs_mem_wr),  32'd0);
        idle(1);
        chk("t5_resume", 32'(obs_mem_addr), 32'h0050);
        idle(3);

        // Three full fill/drain rounds wrap the pointers; 12 writes to dmem.
        wr_pulses = 0;
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < DEPTH; k++)
                step(1'b1, 1'b1, 16'(16'h0100 + 8 * r + 2 * k), 16'(16'hE000 + 16 * r + k));
            idle(DEPTH);
        end
        chk("t6_writes", 32'(wr_pulses), 32'd12);

        // Reset mid-run with three entries queued.
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 16'(16'h0200 + 2 * k), 16'(16'hF000 + k));
        rst_n = 1'b0;
        #1;
        chk("t1_empty", 32'(bus.empty),  32'd1);
        chk("t1_mem_wr", 32'(bus.mem_wr), 32'd0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        wr_pulses = 0;
        idle(5);
        chk("t1_no_writes", 32'(wr_pulses), 32'd0);

        // Randomized traffic over a small address set so hits are frequent.
        for (int n = 0; n < 300; n++) begin
            int op;
            op = int'($urandom_range(0, 3));
            step(op == 1 || op == 3, op == 2 || op == 3,
                 16'(2 * $urandom_range(0, 3)), DATA_W'($urandom));
        end
        idle(DEPTH + 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
